// File: rtl/ttl_tester_pkg.sv
// Shared encodings, pin maps and per-chip helper functions for the 74xx gate-chip tester.
package ttl_tester_pkg;

  localparam int unsigned PIN_W  = 14;
  localparam int unsigned GATE_W = 6;

  typedef enum logic [1:0] {
    CHIP_7404 = 2'b00,
    CHIP_7408 = 2'b01,
    CHIP_7432 = 2'b10,
    CHIP_RSVD = 2'b11
  } chip_e;

  // Sequencer states, kept as a plain encoded set for legacy tooling.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_APPLY = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [2:0] NVEC_HEX  = 3'd2;
  localparam logic [2:0] NVEC_QUAD = 3'd4;

  localparam logic [PIN_W-1:0] IDLE_DRIVE = 14'h2000;

  // Zero-based bit positions in pin_drive / pin_sense (pin number minus one).
  localparam logic [3:0] PIN_GND = 4'd6;
  localparam logic [3:0] PIN_VCC = 4'd13;
  localparam logic [3:0] HEX_A  [6] = '{4'd0, 4'd2, 4'd4, 4'd8, 4'd10, 4'd12};
  localparam logic [3:0] HEX_Y  [6] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9,  4'd11};
  localparam logic [3:0] QUAD_A [4] = '{4'd0, 4'd3, 4'd8, 4'd11};
  localparam logic [3:0] QUAD_B [4] = '{4'd1, 4'd4, 4'd9, 4'd12};
  localparam logic [3:0] QUAD_Y [4] = '{4'd2, 4'd5, 4'd7, 4'd10};

  function automatic logic [2:0] vec_count(input chip_e chip);
    return (chip == CHIP_7404) ? NVEC_HEX : NVEC_QUAD;
  endfunction

  function automatic logic [GATE_W-1:0] gate_mask(input chip_e chip);
    case (chip)
      CHIP_7404:            return 6'h3F;
      CHIP_7408, CHIP_7432: return 6'h0F;
      default:              return 6'h00;
    endcase
  endfunction

  // Rotated vector (v+g) mod N; only the low two bits of g matter for N = 2 or 4.
  function automatic logic gate_a(input chip_e chip, input logic [1:0] v, input logic [1:0] g);
    logic [1:0] s;
    s = v + g;
    return (chip == CHIP_7404) ? s[0] : s[1];
  endfunction

  function automatic logic gate_b(input logic [1:0] v, input logic [1:0] g);
    logic [1:0] s;
    s = v + g;
    return s[0];
  endfunction

  function automatic logic gate_expect(input chip_e chip, input logic a, input logic b);
    case (chip)
      CHIP_7404: return ~a;
      CHIP_7408: return a & b;
      CHIP_7432: return a | b;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ttl_chip_tester_if.sv
// Host and socket signals of the gate-chip tester.
interface ttl_chip_tester_if;
  import ttl_tester_pkg::*;

  logic                start;
  logic [1:0]          chip_sel;
  logic [PIN_W-1:0]    pin_drive;
  logic [PIN_W-1:0]    pin_sense;
  logic                busy;
  logic                done;
  logic                pass;
  logic [GATE_W-1:0]   fail_mask;
  logic [1:0]          pattern;

  modport master (
    output start, chip_sel, pin_sense,
    input  pin_drive, busy, done, pass, fail_mask, pattern
  );

  modport slave (
    input  start, chip_sel, pin_sense,
    output pin_drive, busy, done, pass, fail_mask, pattern
  );
endinterface

// File: rtl/ttl_pin_map.sv
// Combinational gate <-> pin translation for the 7404 and 7408/7432 pinouts.
module ttl_pin_map
  import ttl_tester_pkg::*;
(
  input  chip_e             chip,
  input  logic [5:0]        a,
  input  logic [3:0]        b,
  input  logic [PIN_W-1:0]  pin_sense,
  output logic [PIN_W-1:0]  drive,
  output logic [GATE_W-1:0] sensed
);

  // Supply and input-only pins are never sensed.
  logic unused_sense;
  assign unused_sense = ^{pin_sense[0], pin_sense[4], pin_sense[6],
                          pin_sense[8], pin_sense[12], pin_sense[13]};

  always_comb begin
    drive          = '0;
    drive[PIN_VCC] = 1'b1;
    drive[PIN_GND] = 1'b0;
    sensed         = '0;
    case (chip)
      CHIP_7404: begin
        drive[HEX_A[0]] = a[0];
        drive[HEX_A[1]] = a[1];
        drive[HEX_A[2]] = a[2];
        drive[HEX_A[3]] = a[3];
        drive[HEX_A[4]] = a[4];
        drive[HEX_A[5]] = a[5];
        sensed = {pin_sense[HEX_Y[5]], pin_sense[HEX_Y[4]], pin_sense[HEX_Y[3]],
                  pin_sense[HEX_Y[2]], pin_sense[HEX_Y[1]], pin_sense[HEX_Y[0]]};
      end
      CHIP_7408, CHIP_7432: begin
        drive[QUAD_A[0]] = a[0];
        drive[QUAD_B[0]] = b[0];
        drive[QUAD_A[1]] = a[1];
        drive[QUAD_B[1]] = b[1];
        drive[QUAD_A[2]] = a[2];
        drive[QUAD_B[2]] = b[2];
        drive[QUAD_A[3]] = a[3];
        drive[QUAD_B[3]] = b[3];
        sensed = {2'b00, pin_sense[QUAD_Y[3]], pin_sense[QUAD_Y[2]],
                  pin_sense[QUAD_Y[1]], pin_sense[QUAD_Y[0]]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ttl_chip_tester.sv
// Pin-level sequencer testing a 7404/7408/7432 against its truth table.
// Define TTL_TESTER_STOP_ON_FAIL_EN to end a run at the first failing CHECK.
module ttl_chip_tester
  import ttl_tester_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic               clock,
  input  logic               resetn,
  ttl_chip_tester_if.slave   bus
);

  state_t              state, state_d;
  logic [3:0]          cnt, cnt_d;
  chip_e               chip_q, chip_d;
  logic [PIN_W-1:0]    drive_q, drive_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [GATE_W-1:0]   fail_q, fail_d;
  logic [1:0]          pat_q, pat_d;

  chip_e               sel_c, map_chip;
  logic [1:0]          nv;
  logic [5:0]          a_nxt;
  logic [3:0]          b_nxt;
  logic [PIN_W-1:0]    map_drive;
  logic [GATE_W-1:0]   sensed, exp_y, mism;
  logic                last, stop;

  assign sel_c    = chip_e'(bus.chip_sel);
  // The map serves the vector about to be loaded: vector 0 from IDLE, v+1 from CHECK.
  assign map_chip = (state == ST_IDLE) ? sel_c : chip_q;
  assign nv       = (state == ST_CHECK) ? pat_q + 2'd1 : 2'd0;

  for (genvar g = 0; g < 6; g++) begin : g_gate
    assign a_nxt[g] = gate_a(map_chip, nv, 2'(g));
    assign exp_y[g] = gate_expect(chip_q, gate_a(chip_q, pat_q, 2'(g)), gate_b(pat_q, 2'(g)));
  end
  for (genvar g = 0; g < 4; g++) begin : g_quad
    assign b_nxt[g] = gate_b(nv, 2'(g));
  end

  ttl_pin_map u_map (
    .chip      (map_chip),
    .a         (a_nxt),
    .b         (b_nxt),
    .pin_sense (bus.pin_sense),
    .drive     (map_drive),
    .sensed    (sensed)
  );

  assign mism = gate_mask(chip_q) & (sensed ^ exp_y);
  assign last = ({1'b0, pat_q} == vec_count(chip_q) - 3'd1);

`ifdef TTL_TESTER_STOP_ON_FAIL_EN
  assign stop = |mism;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      chip_q  <= CHIP_7404;
      drive_q <= IDLE_DRIVE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      pat_q   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      chip_q  <= chip_d;
      drive_q <= drive_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    chip_d  = chip_q;
    drive_d = drive_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    pat_d   = pat_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          pass_d = 1'b0;
          fail_d = '0;
          pat_d  = '0;
          chip_d = sel_c;
          if (sel_c == CHIP_RSVD) begin
            state_d = ST_DONE;
            fail_d  = 6'h3F;
          end else begin
            state_d = ST_APPLY;
            drive_d = map_drive;
          end
        end
      end
      ST_APPLY: begin
        cnt_d   = '0;
        state_d = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
      end
      ST_WAIT: begin
        if (cnt == 4'(SETTLE - 1)) state_d = ST_CHECK;
        else                       cnt_d   = cnt + 4'd1;
      end
      ST_CHECK: begin
        fail_d = fail_q | mism;
        if (last || stop) begin
          state_d = ST_DONE;
          pass_d  = (fail_d == '0);
          drive_d = IDLE_DRIVE;
        end else begin
          state_d = ST_APPLY;
          pat_d   = pat_q + 2'd1;
          drive_d = map_drive;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_APPLY) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  assign bus.pin_drive = drive_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_q;
  assign bus.pattern   = pat_q;

endmodule

// File: tb/tb_ttl_chip_tester.sv
// Self-checking bench: pin-level chip model with stuck-pin faults and a run-level reference.
module tb_ttl_chip_tester;

  localparam int unsigned SETTLE = 2;
  localparam int          STEP   = SETTLE + 2;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  ttl_chip_tester_if bus ();

  ttl_chip_tester #(.SETTLE(SETTLE)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          model_chip = 0;
  logic [13:0] fmask = '0;
  logic [13:0] fval = '0;
  logic [13:0] sense_c;

  // Pins are numbered 1..14 as printed on the datasheet.
  function automatic logic getb(input logic [13:0] v, input int p);
    logic [13:0] t;
    t = v >> (p - 1);
    return t[0];
  endfunction

  function automatic logic [13:0] setb(input logic [13:0] v, input int p, input logic b);
    return (v & ~(14'd1 << (p - 1))) | (14'(b) << (p - 1));
  endfunction

  function automatic int hex_a_pin(input int g);
    return (g < 3) ? 2 * g + 1 : 2 * g + 3;
  endfunction

  function automatic int hex_y_pin(input int g);
    return 2 * g + 2;
  endfunction

  // k: 0 = input a, 1 = input b, 2 = output
  function automatic int quad_pin(input int g, input int k);
    case (g)
      0:       return 1 + k;
      1:       return 4 + k;
      2:       return (k == 2) ? 8 : 9 + k;
      default: return (k == 2) ? 11 : 12 + k;
    endcase
  endfunction

  // Chip in the socket, with optional stuck output pins.
  always_comb begin
    sense_c = bus.pin_drive;
    if (model_chip == 0) begin
      for (int g = 0; g < 6; g++)
        sense_c = setb(sense_c, hex_y_pin(g), !getb(bus.pin_drive, hex_a_pin(g)));
    end else if (model_chip == 1 || model_chip == 2) begin
      for (int g = 0; g < 4; g++)
        sense_c = setb(sense_c, quad_pin(g, 2),
                       (model_chip == 1) ?
                         (getb(bus.pin_drive, quad_pin(g, 0)) & getb(bus.pin_drive, quad_pin(g, 1))) :
                         (getb(bus.pin_drive, quad_pin(g, 0)) | getb(bus.pin_drive, quad_pin(g, 1))));
    end
    bus.pin_sense = (sense_c & ~fmask) | (fval & fmask);
  end

  function automatic logic [13:0] exp_drive(input int chip, input int v);
    logic [13:0] d;
    int n, vec;
    d = 14'h2000;
    n = (chip == 0) ? 2 : 4;
    for (int g = 0; g < ((chip == 0) ? 6 : 4); g++) begin
      vec = (v + g) % n;
      if (chip == 0) begin
        d = setb(d, hex_a_pin(g), 1'(vec));
      end else begin
        d = setb(d, quad_pin(g, 0), 1'(vec >> 1));
        d = setb(d, quad_pin(g, 1), 1'(vec));
      end
    end
    return d;
  endfunction

  task automatic predict(input int chip, input logic [13:0] fm, input logic [13:0] fv,
                         output int nrun, output logic [5:0] mask, output logic ok);
    int n, vec, ypin;
    logic a, b, e, act;
    logic [5:0] step;
    mask = '0;
    nrun = 0;
    ok   = 1'b0;
    if (chip == 3) begin
      mask = 6'h3F;
      return;
    end
    n    = (chip == 0) ? 2 : 4;
    nrun = n;
    for (int v = 0; v < n; v++) begin
      step = '0;
      for (int g = 0; g < ((chip == 0) ? 6 : 4); g++) begin
        vec = (v + g) % n;
        if (chip == 0) begin
          a = 1'(vec); b = 1'b0; e = !a; ypin = hex_y_pin(g);
        end else begin
          a = 1'(vec >> 1); b = 1'(vec);
          e = (chip == 1) ? (a & b) : (a | b);
          ypin = quad_pin(g, 2);
        end
        act = getb(fm, ypin) ? getb(fv, ypin) : e;
        if (act != e) step = step | (6'd1 << g);
      end
      mask = mask | step;
`ifdef TTL_TESTER_STOP_ON_FAIL_EN
      if (step != '0) begin
        nrun = v + 1;
        break;
      end
`endif
    end
    ok = (mask == '0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete run; noise adds ignored start pulses and chip_sel churn while busy/DONE.
  task automatic run(input int chip, input logic [13:0] fm, input logic [13:0] fv, input bit noise);
    int nrun, endk;
    logic [5:0] mask;
    logic ok;
    predict(chip, fm, fv, nrun, mask, ok);
    model_chip = chip;
    fmask = fm;
    fval  = fv;
    endk  = nrun * STEP;
    @(negedge clock);
    bus.start    = 1'b1;
    bus.chip_sel = 2'(chip);
    for (int k = 0; k <= endk + 1; k++) begin
      @(negedge clock);
      bus.start = (noise && k <= endk) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) bus.chip_sel = 2'($urandom_range(0, 3));
      if (k < endk) begin
        chk("busy_run", 32'(bus.busy), 32'(1));
        chk("done_run", 32'(bus.done), 32'(0));
        chk("pass_run", 32'(bus.pass), 32'(0));
        chk("pattern", 32'(bus.pattern), 32'(k / STEP));
        chk("pin_drive", 32'(bus.pin_drive), 32'(exp_drive(chip, k / STEP)));
      end else if (k == endk) begin
        chk("done_pulse", 32'(bus.done), 32'(1));
        chk("busy_done", 32'(bus.busy), 32'(0));
        chk("pass", 32'(bus.pass), 32'(ok));
        chk("fail_mask", 32'(bus.fail_mask), 32'(mask));
        chk("drive_done", 32'(bus.pin_drive), 32'(14'h2000));
      end else begin
        chk("done_idle", 32'(bus.done), 32'(0));
        chk("busy_idle", 32'(bus.busy), 32'(0));
        chk("pass_held", 32'(bus.pass), 32'(ok));
        chk("mask_held", 32'(bus.fail_mask), 32'(mask));
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int chip, g, p;
    logic [13:0] fm, fv;

    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.chip_sel = 2'b00;
    repeat (3) @(negedge clock);
    chk("rst_drive", 32'(bus.pin_drive), 32'(14'h2000));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_pass", 32'(bus.pass), 32'(0));
    chk("rst_mask", 32'(bus.fail_mask), 32'(0));
    chk("rst_pattern", 32'(bus.pattern), 32'(0));
    resetn = 1'b1;
    @(negedge clock);

    run(0, 14'd0, 14'd0, 1'b0);                              // good 7404
    run(1, 14'd0, 14'd0, 1'b1);                              // good 7408, stray starts
    run(2, setb(14'd0, 11, 1'b1), 14'd0, 1'b0);              // 7432, pin 11 stuck low
    run(3, 14'd0, 14'd0, 1'b1);                              // reserved chip_sel
    run(1, setb(14'd0, 3, 1'b1), setb(14'd0, 3, 1'b1), 1'b0); // 7408, pin 3 stuck high

    // Reset while in WAIT of vector 2 of a 7408 run.
    model_chip = 1;
    fmask = '0;
    fval  = '0;
    @(negedge clock);
    bus.start    = 1'b1;
    bus.chip_sel = 2'b01;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'(1));
    chk("pre_rst_pattern", 32'(bus.pattern), 32'(2));
    resetn = 1'b0;
    @(negedge clock);
    chk("mid_rst_busy", 32'(bus.busy), 32'(0));
    chk("mid_rst_drive", 32'(bus.pin_drive), 32'(14'h2000));
    chk("mid_rst_pass", 32'(bus.pass), 32'(0));
    chk("mid_rst_pattern", 32'(bus.pattern), 32'(0));
    resetn = 1'b1;
    run(0, 14'd0, 14'd0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      chip = int'($urandom_range(0, 2));
      fm = '0;
      fv = '0;
      if ($urandom_range(0, 1) == 1) begin
        g  = (chip == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
        p  = (chip == 0) ? hex_y_pin(g) : quad_pin(g, 2);
        fm = setb(14'd0, p, 1'b1);
        fv = setb(14'd0, p, 1'($urandom_range(0, 1)));
      end
      run(chip, fm, fv, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ttl_chip_tester.md
# ttl_chip_tester

Sequencer that exercises one 74xx gate-chip model (7404 hex inverter, 7408 quad AND, 7432 quad OR) at pin level. It drives every stimulus vector onto the chip's input pins, waits a settle interval, samples the output pins and compares each gate against its truth table. It sits on the lab bench between the switches/LEDs and the chip socket and reports per-gate pass/fail.

## Interface
- SETTLE, default 2: idle cycles between driving a vector and the CHECK cycle; range 0..15.
- clock  in  1  rising-edge clock, the only clock in the block.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  begin a test run; honoured only in IDLE.
- chip_sel  in  2  chip under test: 00 = 7404, 01 = 7408, 10 = 7432, 11 = reserved. Latched when start is accepted.
- pin_drive  out  14  bit i drives chip pin i+1. Bit 6 (pin 7, GND) is always 0. Bit 13 (pin 14, VCC) is always 1. Bits on chip output pins are 0.
- pin_sense  in  14  bit i is the sensed level of chip pin i+1.
- busy  out  1  high in APPLY, WAIT and CHECK.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  1 when the last run found no mismatch; held until the next accepted start.
- fail_mask  out  6  bit g = 1 when gate g mismatched on any vector; held until the next accepted start.
- pattern  out  2  index of the vector currently driven.

## Operation
- Pin map for 7404: gate g input/output pins are (1,2), (3,4), (5,6), (9,8), (11,10), (13,12) for g = 0..5. Expected output = !a.
- Pin map for 7408/7432: gate g input/input/output pins are (1,2,3), (4,5,6), (9,10,8), (12,13,11) for g = 0..3. Expected output = a&b for 7408 and a|b for 7432.
- Unused gates 4 and 5 on 7408/7432 always have fail_mask bits 4 and 5 = 0.
- Vector count N: 2 for 7404 (a = 0,1); 4 for 7408/7432 (ab = 00,01,10,11, a is the MSB).
- On step v, gate g receives vector (v+g) mod N. This rotation makes adjacent gates see different inputs, so pin shorts are exposed.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
  - IDLE -> APPLY on start & valid chip_sel. IDLE -> DONE on start with chip_sel = 11.
  - APPLY -> WAIT when SETTLE > 0, otherwise APPLY -> CHECK.
  - WAIT counts SETTLE cycles, then -> CHECK.
  - CHECK samples pin_sense and ORs mismatches into fail_mask. CHECK -> DONE on the last vector, otherwise -> APPLY with v+1.
  - DONE -> IDLE unconditionally.
- Accepting start clears pass, fail_mask and pattern.
- On entry to DONE: pass = (fail_mask == 0) for a valid chip. For chip_sel = 11: pass = 0 and fail_mask = 6'h3F.
- Boundary conditions:
  - start while busy or in DONE is ignored.
  - chip_sel changes mid-run are ignored.
  - resetn = 0 in any state -> IDLE on the next edge.
- Reset values and the IDLE/DONE drive level:
  - pin_drive = 14'h2000 (only the VCC bit set).
  - busy = 0, done = 0, pass = 0, fail_mask = 0, pattern = 0.

## Timing
- start is sampled at edge E. The edge entering APPLY loads pin_drive with vector v, so vector v is visible after edge E + v·(SETTLE+2).
- Vector v is sampled from pin_sense during its CHECK cycle. That cycle ends at edge E + (v+1)·(SETTLE+2).
- DONE is entered at edge E + N·(SETTLE+2). done, pass and fail_mask are valid in that cycle. IDLE follows on the next edge.
- Cycle counts with SETTLE = 2: 7404 gives done after E+8; 7408/7432 give done after E+16. Reserved chip_sel gives done after E.
- pin_drive is registered with no combinational path from pin_sense. The block assumes pin_sense is synchronous to clock; the bench wires the chip model directly.

## Configuration
- TTL_TESTER_STOP_ON_FAIL_EN defined: a CHECK with any mismatch goes directly to DONE, and the remaining vectors are skipped.
- TTL_TESTER_STOP_ON_FAIL_EN undefined: all N vectors always run, so fail_mask is complete.

## Structure
- Package ttl_tester_pkg holds:
  - chip_sel encodings;
  - the FSM state enum;
  - vector counts per chip;
  - pin index constants for GND, VCC and each gate.
- One combinational sub-module, ttl_pin_map, does the gate/pin translation:
  - inputs: chip type and per-gate a/b;
  - outputs: the pin_drive vector and per-gate sensed outputs extracted from pin_sense.

## Test plan
- 7404 model wired, SETTLE = 2, start -> done after E+8, pass = 1, fail_mask = 0.
- 7408 model wired -> done after E+16, pass = 1, fail_mask = 0. Pin 1..3 drive sequence for gate 0 is ab = 00, 01, 10, 11.
- 7432 with pin 11 forced 0 -> pass = 0, fail_mask = 6'b001000.
- chip_sel = 11, start -> done after E, pass = 0, fail_mask = 6'h3F. A second start pulse while busy during a 7408 run has no effect on timing.
- resetn low during WAIT of vector 2 -> next edge: busy = 0, pin_drive = 14'h2000. A fresh 7404 run then passes.
- With TTL_TESTER_STOP_ON_FAIL_EN, 7408 with pin 3 forced 1 -> done after E+4, fail_mask = 6'b000001. Without the macro -> done after E+16, fail_mask = 6'b000001.
